dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter that shares the single-ported data RAM between the core load/store unit (port 0) and the memory loader/debug master (port 1). It sits between both requesters and the RAM's write-enable/address/write-data/read-data pins, grants at most one access per cycle, checks addresses, and returns registered read data with a per-port valid strobe. Port 1 may lock the RAM across consecutive accesses for burst program loads.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; word index is addr[31:2].
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  port 0 access request; held with its fields until m0_gnt
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_gnt  out  1  port 0 access performed this cycle (combinational)
- m0_rvalid  out  1  port 0 response valid, one cycle after grant
- m0_rdata  out  32  port 0 read data, valid with m0_rvalid
- m0_err  out  1  port 0 access faulted, valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1
- m1_lock  in  1  port 1 keeps ownership after this granted access
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM byte address (selected port's address)
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM combinational read data for ram_addr

## Operation
- State: last (last granted port, 1 bit), owner (port 1 lock held, 1 bit), per-port rvalid/rdata/err registers.
- Arbitration, combinational each cycle:
  - owner=1: only port 1 may be granted; m0_gnt=0 regardless of m0_req.
  - owner=0, one request: that port granted.
  - owner=0, both requests: grant port !last.
  - No request: no grant; ram_we=0, ram_addr/ram_wdata = port 0 fields.
- Mux: ram_addr/ram_wdata come from the granted port. ram_we = granted port's we AND access legal AND !rst.
- Legal access: addr[1:0]==0 and addr[31:2] < DEPTH_WORDS. Illegal: grant still given, ram_we=0, response err=1, rdata=0.
- Response: on grant, granted port's rvalid←1, err←illegal, rdata←ram_rdata for a legal read, else 0. A write responds with rvalid=1, rdata=0. rvalid of a non-granted port ←0.
- last←granted port on any grant; unchanged otherwise.
- owner: ←1 when port 1 granted with m1_lock=1; ←0 when port 1 granted with m1_lock=0, or when owner=1 and m1_req=0.

## Timing
- Grant: same cycle as request (zero-wait when uncontended); RAM write commits at that rising edge.
- Read latency: rdata/rvalid/err at cycle N+1 for grant at cycle N; rvalid is a 1-cycle pulse per grant; back-to-back grants give back-to-back rvalid.
- Requester must hold req/we/addr/wdata stable until gnt; may change or drop them the cycle after gnt.
- Reset (rst=1 at edge): last←1 (port 0 wins first contention), owner←0, all rvalid/err←0, all rdata←0. While rst=1: m0_gnt=m1_gnt=0, ram_we=0. Access requested during reset is not performed; no response is produced for it.
- Reset mid-lock: owner cleared; arbitration resumes round-robin the cycle after rst deasserts.
- Word addressing: ram_addr is passed through unmodified; the RAM drops addr[1:0].
- Boundary: addr = 4*(DEPTH_WORDS-1) is legal; 4*DEPTH_WORDS is illegal (err=1, no write, no wrap-around to word 0).

## Test plan
- Port 0 write 0xDEADBEEF to 0x10, then read 0x10 -> m0_gnt both cycles, m0_rvalid the cycle after each, read m0_rdata=0xDEADBEEF, m0_err=0.
- Both ports request reads every cycle after reset -> grants alternate 0,1,0,1; each rvalid/rdata on the correct port one cycle later.
- Port 1 writes 4 words 0x100..0x10C with m1_lock=1 on the first 3, m1_lock=0 on the last, while m0_req held high -> m0_gnt=0 for those 4 cycles, m0 granted on cycle 5.
- Port 0 write to 0x0000_1000 (DEPTH_WORDS=1024) and to 0x0000_0006 -> m0_gnt=1, ram_we=0, m0_err=1, m0_rdata=0; RAM word 0 and word 1 unchanged.
- Port 1 locked, then m1_req drops with no grant -> owner cleared next cycle; pending m0 request granted.
- rst asserted for one cycle during a locked burst with both ports requesting -> no gnt, ram_we=0 in that cycle; all rvalid=0 after; next contention grants port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-ported data RAM between the core LSU (port 0)
// and the loader/debug master (port 1), with address checking and registered responses.
module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_lock_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        gnt0, gnt1, any_gnt, sel_we, legal;
  logic [31:0] sel_addr, sel_wdata, resp_rdata;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (owner_q) begin
        gnt1 = m1_req_i;
      end else if (m0_req_i && m1_req_i) begin
        // last_q names the port that went most recently; the other one wins
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
  assign sel_we    = gnt1 ? m1_we_i    : m0_we_i;
  assign legal     = (sel_addr[1:0] == 2'b00) && ({2'b00, sel_addr[31:2]} < DEPTH_WORDS);
  assign resp_rdata = (legal && !sel_we) ? ram_rdata_i : 32'h0;

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign ram_we_o    = any_gnt & sel_we & legal & ~rst_i;
  assign ram_addr_o  = sel_addr;
  assign ram_wdata_o = sel_wdata;

  always_comb begin
    last_d    = any_gnt ? gnt1 : last_q;
    owner_d   = owner_q;
    if (gnt1) begin
      owner_d = m1_lock_i;
    end else if (owner_q && !m1_req_i) begin
      owner_d = 1'b0;
    end
    rvalid0_d = gnt0;
    rvalid1_d = gnt1;
    err0_d    = gnt0 ? !legal : err0_q;
    err1_d    = gnt1 ? !legal : err1_q;
    rdata0_d  = gnt0 ? resp_rdata : rdata0_q;
    rdata1_d  = gnt1 ? resp_rdata : rdata1_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      last_q    <= last_d;
      owner_q   <= owner_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m0_rvalid_o = rvalid0_q;
  assign m0_rdata_o  = rdata0_q;
  assign m0_err_o    = err0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m1_rdata_o  = rdata1_q;
  assign m1_err_o    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024-word RAM attached.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic [31:0] mem [0:1023];
  logic        mem_init;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH_WORDS(1024)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_lock_i(m1_lock),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // RAM drops addr[1:0]; out-of-range addresses alias, so illegal writes would show up
  assign ram_rdata = mem[ram_addr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h1111_1111;
      mem[1] <= 32'h2222_2222;
      mem[8] <= 32'hA0A0_0008;
      mem[9] <= 32'hB1B1_0009;
    end else if (ram_we) begin
      mem[ram_addr[11:2]] <= ram_wdata;
    end
  end

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
  endtask

  task automatic test_reset();
    rst = 1; mem_init = 1; idle();
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    @(negedge clk); #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, ram_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_gnt: got gnt0/gnt1/we=%b expected 000", {m0_gnt, m1_gnt, ram_we});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000 || m0_rdata !== 0 || m1_rdata !== 0) begin
      n_fail++; $display("FAIL reset_resp: got rv/err=%b rd0=%h rd1=%h expected all 0",
                         {m0_rvalid, m1_rvalid, m0_err, m1_err}, m0_rdata, m1_rdata);
    end
    @(negedge clk);
    mem_init = 0; rst = 0; idle();
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d;
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h24;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_checks++;
      if (m0_gnt !== (k % 2 == 0) || m1_gnt !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got gnt0=%b gnt1=%b expected port %0d", k, m0_gnt, m1_gnt, k % 2);
      end
      @(posedge clk); #1;
      exp_d = (k % 2 == 0) ? 32'hA0A0_0008 : 32'hB1B1_0009;
      n_checks++;
      if (m0_rvalid !== (k % 2 == 0) || m1_rvalid !== (k % 2 == 1) ||
          ((k % 2 == 0) ? m0_rdata : m1_rdata) !== exp_d) begin
        n_fail++; $display("FAIL rr_resp[%0d]: got rv0=%b rv1=%b rd0=%h rd1=%h expected data %h",
                           k, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, exp_d);
      end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; #1;
    n_checks++;
    if (m0_gnt !== 1 || ram_we !== 1 || ram_addr !== 32'h10) begin
      n_fail++; $display("FAIL wr_gnt: got gnt=%b we=%b addr=%h expected 1 1 00000010", m0_gnt, ram_we, ram_addr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 0 || m0_err !== 0 || mem[4] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_resp: got rv=%b rd=%h err=%b mem=%h expected 1 0 0 deadbeef",
                         m0_rvalid, m0_rdata, m0_err, mem[4]);
    end
    @(negedge clk);
    m0_we = 0; m0_wdata = 0; #1;
    n_checks++;
    if (m0_gnt !== 1 || ram_we !== 0) begin
      n_fail++; $display("FAIL rd_gnt: got gnt=%b we=%b expected 1 0", m0_gnt, ram_we);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 32'hDEAD_BEEF || m0_err !== 0) begin
      n_fail++; $display("FAIL rd_resp: got rv=%b rd=%h err=%b expected 1 deadbeef 0", m0_rvalid, m0_rdata, m0_err);
    end
    @(negedge clk); idle();
    @(posedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 0) begin
      n_fail++; $display("FAIL rv_pulse: got rv=%b expected 0", m0_rvalid);
    end
  endtask

  task automatic test_lock_burst();
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h20;
    m1_req = 1; m1_we = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      m1_addr = 32'h100 + 32'(4 * k); m1_wdata = 32'hC0DE_0000 + 32'(k); m1_lock = (k < 3);
      #1;
      n_checks++;
      if (m0_gnt !== 0 || m1_gnt !== 1 || ram_we !== 1 || ram_addr !== m1_addr) begin
        n_fail++; $display("FAIL burst_gnt[%0d]: got gnt0=%b gnt1=%b we=%b addr=%h expected 0 1 1 %h",
                           k, m0_gnt, m1_gnt, ram_we, ram_addr, m1_addr);
      end
      @(posedge clk); #1;
      n_checks++;
      if (m1_rvalid !== 1 || m0_rvalid !== 0 || m1_err !== 0) begin
        n_fail++; $display("FAIL burst_resp[%0d]: got rv1=%b rv0=%b err1=%b expected 1 0 0", k, m1_rvalid, m0_rvalid, m1_err);
      end
    end
    @(negedge clk);
    m1_req = 0; m1_we = 0; m1_lock = 0; #1;
    n_checks++;
    if (m0_gnt !== 1) begin
      n_fail++; $display("FAIL burst_release: got gnt0=%b expected 1", m0_gnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem[64] !== 32'hC0DE_0000 || mem[65] !== 32'hC0DE_0001 ||
        mem[66] !== 32'hC0DE_0002 || mem[67] !== 32'hC0DE_0003 || m0_rdata !== 32'hA0A0_0008) begin
      n_fail++; $display("FAIL burst_data: got %h %h %h %h rd0=%h expected c0de0000..3 a0a00008",
                         mem[64], mem[65], mem[66], mem[67], m0_rdata);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [3];
    addrs[0] = 32'h1000; addrs[1] = 32'h6; addrs[2] = 32'h1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m0_req = 1; m0_we = (k < 2); m0_addr = addrs[k]; m0_wdata = 32'hFFFF_FFFF; #1;
      n_checks++;
      if (m0_gnt !== 1 || ram_we !== 0) begin
        n_fail++; $display("FAIL illegal_gnt[%0d]: got gnt=%b we=%b expected 1 0", k, m0_gnt, ram_we);
      end
      @(posedge clk); #1;
      n_checks++;
      if (m0_rvalid !== 1 || m0_err !== 1 || m0_rdata !== 0) begin
        n_fail++; $display("FAIL illegal_resp[%0d]: got rv=%b err=%b rd=%h expected 1 1 0", k, m0_rvalid, m0_err, m0_rdata);
      end
    end
    n_checks++;
    if (mem[0] !== 32'h1111_1111 || mem[1] !== 32'h2222_2222) begin
      n_fail++; $display("FAIL illegal_mem: got w0=%h w1=%h expected 11111111 22222222", mem[0], mem[1]);
    end
    @(negedge clk);
    m0_we = 1; m0_addr = 32'hFFC; m0_wdata = 32'h5A5A_A5A5; #1;
    n_checks++;
    if (m0_gnt !== 1 || ram_we !== 1) begin
      n_fail++; $display("FAIL top_word_wr: got gnt=%b we=%b expected 1 1", m0_gnt, ram_we);
    end
    @(posedge clk); #1;
    @(negedge clk);
    m0_we = 0;
    @(posedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 1 || m0_err !== 0 || m0_rdata !== 32'h5A5A_A5A5) begin
      n_fail++; $display("FAIL top_word_rd: got rv=%b err=%b rd=%h expected 1 0 5a5aa5a5", m0_rvalid, m0_err, m0_rdata);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_lock_drop();
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h200; m1_wdata = 32'h77; #1;
    n_checks++;
    if (m1_gnt !== 1) begin
      n_fail++; $display("FAIL drop_lock_gnt: got gnt1=%b expected 1", m1_gnt);
    end
    @(negedge clk);
    idle(); m0_req = 1; m0_addr = 32'h20; #1;
    n_checks++;
    if (m0_gnt !== 0 || m1_gnt !== 0) begin
      n_fail++; $display("FAIL drop_owned: got gnt0=%b gnt1=%b expected 0 0", m0_gnt, m1_gnt);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m0_gnt !== 1) begin
      n_fail++; $display("FAIL drop_release: got gnt0=%b expected 1", m0_gnt);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h300; m1_wdata = 32'h99; #1;
    n_checks++;
    if (m1_gnt !== 1) begin
      n_fail++; $display("FAIL rml_lock: got gnt1=%b expected 1", m1_gnt);
    end
    @(negedge clk);
    rst = 1; m1_addr = 32'h304; m1_wdata = 32'hBAD; m0_req = 1; m0_addr = 32'h24; #1;
    n_checks++;
    if (m0_gnt !== 0 || m1_gnt !== 0 || ram_we !== 0) begin
      n_fail++; $display("FAIL rml_rst: got gnt0=%b gnt1=%b we=%b expected 0 0 0", m0_gnt, m1_gnt, ram_we);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 0 || m1_rvalid !== 0 || mem[193] !== 0) begin
      n_fail++; $display("FAIL rml_after: got rv0=%b rv1=%b w193=%h expected 0 0 0", m0_rvalid, m1_rvalid, mem[193]);
    end
    @(negedge clk);
    rst = 0; m1_we = 0; m1_lock = 0; #1;
    n_checks++;
    if (m0_gnt !== 1 || m1_gnt !== 0) begin
      n_fail++; $display("FAIL rml_resume: got gnt0=%b gnt1=%b expected 1 0", m0_gnt, m1_gnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 32'hB1B1_0009) begin
      n_fail++; $display("FAIL rml_resp: got rv0=%b rd0=%h expected 1 b1b10009", m0_rvalid, m0_rdata);
    end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock_burst();
    test_illegal();
    test_lock_drop();
    test_reset_mid_lock();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
